// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target for the CPU load/store port.
// A single word request (load or store) is accepted in IDLE, held for
// WAIT_CYCLES wait states, then answered with a one-cycle ready pulse that
// carries load data or an error flag (misaligned or out-of-range address).
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset (aborts any request in flight)
//   req    request strobe, sampled only while idle
//   we     1 = store word, 0 = load word; sampled with req
//   addr   byte address; sampled with req
//   wdata  store data; sampled with req
//   busy   request in progress
//   ready  one-cycle response strobe
//   rdata  load data, valid with ready, held until the next response
//   err    response error flag, valid with ready
module dmem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam int unsigned CNT_W     = 4;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    // Elaboration-time parameter checks
    if (WAIT_CYCLES > 15) begin : g_wait_range
        $error("dmem_responder: WAIT_CYCLES must be in 0..15");
    end
    if (ADDR_W < 1 || ADDR_W > 29) begin : g_addr_range
        $error("dmem_responder: ADDR_W must be in 1..29");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        mem [DEPTH];

    logic               go_resp;
    logic               acc_we;
    logic               acc_bad;
    logic [31:0]        acc_addr;
    logic [31:0]        acc_wdata;
    logic [ADDR_W-1:0]  acc_idx;

    // The storage access happens on the edge entering RESP. With zero wait
    // states that edge is the accept edge itself, so the live inputs are used
    // instead of the (not yet loaded) latched copies.
    always_comb begin
        go_resp   = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state == IDLE) begin
            go_resp   = req && (WAIT_CYCLES == 0);
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
        end else if (state == WAIT) begin
            go_resp = (cnt == CNT_W'(1));
        end
        acc_bad = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_W + 2)) != 32'd0);
        acc_idx = acc_addr[ADDR_W+1:2];
    end

    // Request FSM, storage and registered response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= WAIT_INIT;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // Response: bad addresses never touch storage and return zero data
            if (go_resp) begin
                ready <= 1'b1;
                err   <= acc_bad;
                if (acc_bad) begin
                    rdata <= '0;
                end else if (acc_we) begin
                    mem[acc_idx] <= acc_wdata;
                end else begin
                    rdata <= mem[acc_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed vector table, randomized traffic
// against a word-array reference model, and hand-written multi-cycle cases
// (held request, reset mid-wait, zero wait states, back-to-back).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic        busy, ready, err;
    logic [31:0] rdata;
    logic        busy0, ready0, err0;
    logic [31:0] rdata0;

    int tests = 0;
    int fails = 0;

    // Reference model state: plain word array plus last response data
    logic [31:0] model_mem [256];
    logic [31:0] model_rdata;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .ready(ready), .rdata(rdata), .err(err)
    );

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy0), .ready(ready0), .rdata(rdata0), .err(err0)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
        model_rdata = 32'd0;
    endtask

    // Response predicted from the address rules with plain arithmetic
    task automatic model_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rd, output logic er);
        if ((a % 32'd4) != 32'd0 || a >= 32'h400) begin
            er = 1'b1;
            model_rdata = 32'd0;
        end else begin
            er = 1'b0;
            if (w) model_mem[int'(a >> 2)] = d;
            else   model_rdata = model_mem[int'(a >> 2)];
        end
        rd = model_rdata;
    endtask

    // One request on the WAIT_CYCLES=2 instance; returns in the IDLE cycle after ready
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat);
        req = 1'b1; we = w; addr = a; wdata = d;
        tick();
        req = 1'b0;
        lat = 1;
        while (!ready && lat < 20) begin
            tick();
            lat++;
        end
        rd = rdata;
        er = err;
        tick();
    endtask

    vec_t        vecs [7];
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int          lat;
    logic [31:0] pend_q [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0402, 32'h0,         32'h0000_0000, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_03FC, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_03FC, 32'h0,         32'h0000_0001, 1'b0};

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_rdata", rdata,      32'd0);
        chk("reset_err",   32'(err),   32'd0);

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            model_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, exp_rd, exp_er);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            logic        w;
            logic [31:0] a, d;
            int          r;
            r = int'($urandom_range(0, 9));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            a = 32'h10 + 32'(4 * $urandom_range(0, 7));
            if (r == 6) a = 32'h3FC;
            if (r == 7) a = a | 32'($urandom_range(1, 3));
            if (r >= 8) a = $urandom | 32'h400;
            do_req(w, a, d, rd, er, lat);
            model_req(w, a, d, exp_rd, exp_er);
            chk($sformatf("rand%0d_rdata", i), rd, exp_rd);
            chk($sformatf("rand%0d_err", i), 32'(er), 32'(exp_er));
            chk($sformatf("rand%0d_latency", i), 32'(lat), 32'd3);
        end

        // req held high with changing addresses: one response every 4 cycles
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("held_c%0d_ready", c), 32'(ready), 32'((c % 4) == 3));
            if (ready) begin
                if (pend_q.size() == 0) chk($sformatf("held_c%0d_queue", c), 32'd1, 32'd0);
                else chk($sformatf("held_c%0d_rdata", c), rdata, pend_q.pop_front());
            end
            req = 1'b1; we = 1'b0; addr = 32'h10 + 32'(4 * (c % 3)); wdata = '0;
            if ((c % 4) == 0) begin
                model_req(1'b0, addr, 32'd0, exp_rd, exp_er);
                pend_q.push_back(exp_rd);
            end
            tick();
        end
        req = 1'b0;
        tick(); tick();

        // Reset during WAIT aborts the store
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
        tick();
        req = 1'b0;
        tick();
        chk("rstwait_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstwait_busy_async",  32'(busy),  32'd0);
        chk("rstwait_ready_async", 32'(ready), 32'd0);
        tick();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("rstwait_no_ready_%0d", c), 32'(ready), 32'd0);
        end
        do_req(1'b0, 32'h20, 32'd0, rd, er, lat);
        chk("rstwait_lw_rdata", rd, 32'd0);
        chk("rstwait_lw_err", 32'(er), 32'd0);

        // Zero wait states: ready one cycle after req
        req = 1'b1; we = 1'b1; addr = 32'h3FC; wdata = 32'hA5A5_A5A5;
        model_req(1'b1, addr, wdata, exp_rd, exp_er);
        tick();
        req = 1'b0;
        chk("w0_sw_ready", 32'(ready0), 32'd1);
        chk("w0_sw_err",   32'(err0),   32'd0);
        tick();
        chk("w0_sw_ready_drop", 32'(ready0), 32'd0);
        tick(); tick(); tick();
        req = 1'b1; we = 1'b0; addr = 32'h3FC; wdata = 32'd0;
        model_req(1'b0, addr, wdata, exp_rd, exp_er);
        tick();
        req = 1'b0;
        chk("w0_lw_ready", 32'(ready0), 32'd1);
        chk("w0_lw_rdata", rdata0, 32'hA5A5_A5A5);
        chk("w0_lw_err",   32'(err0),   32'd0);
        tick(); tick(); tick(); tick();

        // Back-to-back loads: second req in the IDLE cycle right after ready
        do_req(1'b1, 32'h10, 32'h1111_1111, rd, er, lat);
        do_req(1'b1, 32'h14, 32'h2222_2222, rd, er, lat);
        do_req(1'b0, 32'h10, 32'd0, rd, er, lat);
        chk("b2b_first_rdata", rd, 32'h1111_1111);
        req = 1'b1; we = 1'b0; addr = 32'h14;
        tick();
        req = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_hold1_rdata", rdata, 32'h1111_1111);
        tick();
        chk("b2b_hold2_rdata", rdata, 32'h1111_1111);
        chk("b2b_hold2_ready", 32'(ready), 32'd0);
        tick();
        chk("b2b_second_ready", 32'(ready), 32'd1);
        chk("b2b_second_rdata", rdata, 32'h2222_2222);
        tick();
        chk("b2b_ready_pulse", 32'(ready), 32'd0);
        chk("b2b_rdata_held", rdata, 32'h2222_2222);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
